// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults
// and the pattern mode encodings.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int CLK_DIV_D  = 2;
  localparam int COLOR_W_D  = 4;

  typedef enum logic [1:0] {
    MODE_GRAY  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: pixel divider, raster
// counters and sync / visible decode.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int CLK_DIV  = CLK_DIV_D,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          pix_tick,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          vis,
  output logic          hs_act,
  output logic          vs_act,
  output logic          origin
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);

  logic [DW-1:0] div;
  logic [31:0]   hx;
  logic [31:0]   vy;

  assign pix_tick = (div == DIV_MAX);

  // Divider wraps at CLK_DIV-1; raster advances on each tick
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= pix_tick ? '0 : div + DW'(1);
      if (pix_tick) begin
        if (hcnt == H_MAX) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_MAX) ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  assign hx = 32'(hcnt);
  assign vy = 32'(vcnt);

  assign vis = (hx < 32'(H_ACTIVE)) &&
               (vy < 32'(V_ACTIVE));

  assign hs_act =
    (hx >= 32'(H_ACTIVE + H_FP)) &&
    (hx < 32'(H_ACTIVE + H_FP + H_SYNC));

  assign vs_act =
    (vy >= 32'(V_ACTIVE + V_FP)) &&
    (vy < 32'(V_ACTIVE + V_FP + V_SYNC));

  assign origin = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing plus test
// patterns, all outputs registered per pixel.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = CLK_DIV_D,
  parameter int COLOR_W  = COLOR_W_D,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [HW-1:0]      x,
  output logic [VW-1:0]      y,
  output logic               frame_start
);

  localparam logic [COLOR_W-1:0] HALF =
    COLOR_W'(1) << (COLOR_W - 1);

  logic          pix_tick;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          vis;
  logic          hs_act;
  logic          vs_act;
  logic          origin;

  mode_e              mode_q;
  mode_e              mode_eff;
  logic [31:0]        px;
  logic [31:0]        py;
  logic [2:0]         bar;
  logic               on;
  logic [COLOR_W-1:0] pr;
  logic [COLOR_W-1:0] pg;
  logic [COLOR_W-1:0] pb;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .pix_tick (pix_tick),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .vis      (vis),
    .hs_act   (hs_act),
    .vs_act   (vs_act),
    .origin   (origin)
  );

  // The origin pixel already uses the newly sampled mode
  assign mode_eff = origin ? mode_e'(mode) : mode_q;
  assign px = 32'(hcnt);
  assign py = 32'(vcnt);

  // Pattern colour for the current counter position
  always_comb begin
    bar = '0;
    on  = 1'b0;
    pr  = '0;
    pg  = '0;
    pb  = '0;
    for (int i = 1; i < 8; i++) begin
      if ((px << 3) >= 32'(i * H_ACTIVE))
        bar = 3'(i);
    end
    unique case (mode_eff)
      MODE_GRAY: begin
        pr = HALF;
        pg = HALF;
        pb = HALF;
      end
      MODE_BARS: begin
        pr = {COLOR_W{bar[2]}};
        pg = {COLOR_W{bar[1]}};
        pb = {COLOR_W{bar[0]}};
      end
      MODE_CHECK: begin
        on = px[5] ^ py[5];
        pr = {COLOR_W{on}};
        pg = {COLOR_W{on}};
        pb = {COLOR_W{on}};
      end
      MODE_GRID: begin
        on = (px[4:0] == 5'd0) ||
             (py[4:0] == 5'd0) ||
             (px == 32'(H_ACTIVE - 1)) ||
             (py == 32'(V_ACTIVE - 1));
        pr = {COLOR_W{on}};
        pg = {COLOR_W{on}};
        pb = {COLOR_W{on}};
      end
    endcase
    if (!vis) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  // Output stage: one clock behind the counters, held between ticks
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      mode_q      <= MODE_GRAY;
    end else begin
      frame_start <= pix_tick && origin;
      if (pix_tick) begin
        r  <= pr;
        g  <= pg;
        b  <= pb;
        de <= vis;
        hs <= hs_act ? HS_POL : ~HS_POL;
        vs <= vs_act ? VS_POL : ~VS_POL;
        x  <= hcnt;
        y  <= vcnt;
        if (origin)
          mode_q <= mode_e'(mode);
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: two vga_pattern_gen
// instances checked against a raster model.
module tb_vga_pattern_gen;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode    = 2'd1;

  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, de0, fs0;
  logic       hs1, vs1, de1, fs1;
  logic [6:0] x0;
  logic [5:0] y0;
  logic [3:0] x1;
  logic [2:0] y1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vga_pattern_gen #(
    .H_ACTIVE (80), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (40), .V_FP (2), .V_SYNC (3), .V_BP (3),
    .HS_POL (1'b0), .VS_POL (1'b1),
    .CLK_DIV (2), .COLOR_W (4)
  ) u_main (
    .clock (clock), .reset_n (reset_n), .mode (mode),
    .r (r0), .g (g0), .b (b0),
    .hs (hs0), .vs (vs0), .de (de0),
    .x (x0), .y (y0), .frame_start (fs0)
  );

  vga_pattern_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b0),
    .CLK_DIV (1), .COLOR_W (4)
  ) u_tiny (
    .clock (clock), .reset_n (reset_n), .mode (mode),
    .r (r1), .g (g1), .b (b1),
    .hs (hs1), .vs (vs1), .de (de1),
    .x (x1), .y (y1), .frame_start (fs1)
  );

  int   ha  [2] = '{80, 8};
  int   hf  [2] = '{4, 2};
  int   hsw [2] = '{6, 2};
  int   ht  [2] = '{96, 14};
  int   va  [2] = '{40, 4};
  int   vf  [2] = '{2, 1};
  int   vsw [2] = '{3, 1};
  int   vt  [2] = '{48, 7};
  int   dv  [2] = '{2, 1};
  logic hp  [2] = '{1'b0, 1'b1};
  logic vp  [2] = '{1'b1, 1'b0};

  int          e    [2] = '{0, 0};
  int          mf   [2];
  int          mx   [2];
  int          my   [2];
  bit          mtk  [2];
  logic [1:0]  fm   [2] = '{2'd0, 2'd0};
  logic [63:0] expv [2];

  int          bx   [10] = '{0, 9, 10, 15, 35, 45, 55, 70, 79, 80};
  logic [12:0] bexp [10] = '{13'h1000, 13'h1000, 13'h100F,
                             13'h100F, 13'h10FF, 13'h1F00,
                             13'h1F0F, 13'h1FFF, 13'h1FFF,
                             13'h0000};

  bit   probes_on = 1'b1;
  int   cyc       = 0;
  logic prev_hs   = 1'b1;
  logic prev_vs   = 1'b0;
  int   hs_fall   = -1;
  int   hs_per    = 0;
  int   hs_low    = 0;
  int   vs_rise   = -1;
  int   vs_per    = 0;
  int   vs_high   = 0;
  int   fs1_last  = -1;
  int   fs1_per   = 0;
  int   x1_last   = -1;
  int   x1_per    = 0;
  int   fs_cnt    = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t",
               tag, got, want, $time);
    end
  endtask

  function automatic logic [63:0] pack(
    input int px, input int py,
    input logic d, input logic h, input logic v,
    input logic f, input logic [11:0] c);
    return 64'({16'(px), 16'(py), d, h, v, f, c});
  endfunction

  function automatic logic [11:0] pix(
    input int k, input logic [1:0] m,
    input int px, input int py);
    logic [2:0] bar;
    bit         on;
    if (px >= ha[k] || py >= va[k]) return 12'h000;
    case (m)
      2'd0: return 12'h888;
      2'd1: begin
        bar = 3'(px * 8 / ha[k]);
        return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      end
      2'd2: begin
        on = ((px / 32) % 2) != ((py / 32) % 2);
        return {12{on}};
      end
      default: begin
        on = (px % 32 == 0) || (py % 32 == 0) ||
             (px == ha[k] - 1) || (py == va[k] - 1);
        return {12{on}};
      end
    endcase
  endfunction

  // Position follows from clocks elapsed since reset release
  task automatic model_edge(input int k);
    int   t, idx, px, py;
    logic f, d, h, v;
    if (!reset_n) e[k] = 0;
    else e[k]++;
    mtk[k] = 1'b0;
    if (e[k] < dv[k]) begin
      mf[k] = -1; mx[k] = -1; my[k] = -1;
      expv[k] = pack(0, 0, 1'b0, ~hp[k], ~vp[k],
                     1'b0, 12'h000);
    end else begin
      t   = e[k] / dv[k] - 1;
      idx = t % (ht[k] * vt[k]);
      px  = idx % ht[k];
      py  = idx / ht[k];
      mtk[k] = (e[k] % dv[k]) == 0;
      f = mtk[k] && (idx == 0);
      if (f) fm[k] = mode;
      mf[k] = t / (ht[k] * vt[k]);
      mx[k] = px;
      my[k] = py;
      d = (px < ha[k]) && (py < va[k]);
      h = (px >= ha[k] + hf[k] &&
           px < ha[k] + hf[k] + hsw[k]) ? hp[k] : ~hp[k];
      v = (py >= va[k] + vf[k] &&
           py < va[k] + vf[k] + vsw[k]) ? vp[k] : ~vp[k];
      expv[k] = pack(px, py, d, h, v, f,
                     pix(k, fm[k], px, py));
    end
  endtask

  task automatic probe();
    logic [11:0] c;
    c = {r0, g0, b0};
    if (!mtk[0] || !probes_on) return;
    if (mf[0] == 0 && my[0] == 0)
      for (int j = 0; j < 10; j++)
        if (mx[0] == bx[j])
          check("bars", 64'({de0, c}), 64'(bexp[j]));
    if (mf[0] == 1 && my[0] == 30 && mx[0] == 40)
      check("gray_hold", 64'(c), 64'(12'h888));
    if (mf[0] == 2) begin
      if (my[0] == 0 && mx[0] == 32)
        check("chk_32_0", 64'(c), 64'(12'hFFF));
      if (my[0] == 0 && mx[0] == 0)
        check("chk_0_0", 64'(c), 64'(12'h000));
      if (my[0] == 32 && mx[0] == 32)
        check("chk_32_32", 64'(c), 64'(12'h000));
      if (my[0] == 32 && mx[0] == 5)
        check("chk_5_32", 64'(c), 64'(12'hFFF));
    end
    if (mf[0] == 3) begin
      if (my[0] == 5 && mx[0] == 79)
        check("grid_79_5", 64'(c), 64'(12'hFFF));
      if (my[0] == 33 && mx[0] == 33)
        check("grid_33_33", 64'(c), 64'(12'h000));
      if (my[0] == 10 && mx[0] == 90)
        check("grid_90_10", 64'({de0, c}), 64'(13'h0000));
      if (my[0] == 7 && mx[0] == 64)
        check("grid_64_7", 64'(c), 64'(12'hFFF));
      if (my[0] == 39 && mx[0] == 5)
        check("grid_5_39", 64'(c), 64'(12'hFFF));
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    cyc++;
    check("px_main", 64'({16'(x0), 16'(y0), de0, hs0, vs0,
                          fs0, r0, g0, b0}), expv[0]);
    check("px_tiny", 64'({16'(x1), 16'(y1), de1, hs1, vs1,
                          fs1, r1, g1, b1}), expv[1]);
    if (prev_hs && !hs0) begin
      if (hs_fall >= 0) hs_per = cyc - hs_fall;
      hs_fall = cyc;
    end
    if (!prev_hs && hs0 && hs_fall >= 0)
      hs_low = cyc - hs_fall;
    if (!prev_vs && vs0) begin
      if (vs_rise >= 0) vs_per = cyc - vs_rise;
      vs_rise = cyc;
    end
    if (prev_vs && !vs0 && vs_rise >= 0)
      vs_high = cyc - vs_rise;
    prev_hs = hs0;
    prev_vs = vs0;
    if (fs1) begin
      if (fs1_last >= 0) fs1_per = cyc - fs1_last;
      fs1_last = cyc;
    end
    if (x1 == 4'd0) begin
      if (x1_last >= 0) x1_per = cyc - x1_last;
      x1_last = cyc;
    end
    if (fs0) fs_cnt++;
    probe();
  endtask

  task automatic run_to(input int f, input int yy,
                        input int xx, input int budget);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      step();
      n++;
      hit = mtk[0] && mf[0] == f &&
            my[0] == yy && mx[0] == xx;
    end
    check("run_to", 64'(hit), 64'(1));
  endtask

  initial begin
    reset_n = 1'b0;
    mode    = 2'd1;
    repeat (5) step();
    check("rst_hs", 64'(hs0), 64'(1));
    check("rst_vs", 64'(vs0), 64'(0));
    reset_n = 1'b1;
    run_to(0, 20, 0, 20000);
    mode = 2'd0;
    run_to(1, 20, 0, 20000);
    mode = 2'd2;
    run_to(2, 0, 0, 20000);
    check("hs_period", 64'(hs_per), 64'(192));
    check("hs_low", 64'(hs_low), 64'(12));
    check("vs_period", 64'(vs_per), 64'(9216));
    check("vs_high", 64'(vs_high), 64'(576));
    check("tiny_frame", 64'(fs1_per), 64'(98));
    check("tiny_line", 64'(x1_per), 64'(14));
    run_to(2, 20, 0, 20000);
    mode = 2'd3;
    run_to(3, 39, 30, 20000);
    probes_on = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_abort",
          64'({16'(x0), 16'(y0), de0, hs0, vs0, fs0,
               r0, g0, b0}),
          pack(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000));
    reset_n = 1'b1;
    fs_cnt  = 0;
    step();
    check("rst_wait", 64'(fs0), 64'(0));
    step();
    check("restart_fs", 64'(fs0), 64'(1));
    check("restart_xy", 64'({x0, y0}), 64'(0));
    repeat (9214) step();
    check("fs_once", 64'(fs_cnt), 64'(1));
    repeat (12000) begin
      step();
      if ($urandom_range(0, 299) == 0)
        mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2999) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 4)) step();
        reset_n = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
